copy_len: RTL

Parametrised successor of the DMA copy unit. Moves beats from the source FIFO to the destination FIFO under descriptor control, with configurable data width, a programmable beat count, and a fill mode that writes a constant pattern without reading the source. Sits in the comp_unit datapath alongside the other descriptor-selected engines. It drives the shared FIFO strobe, data and end lines only while its select bit in `dc` is set, and leaves them high-impedance otherwise.

---
 rtl/copy_len.sv | 139 +++++++++++++
 1 files changed

// File: rtl/copy_len.sv
`default_nettype none
// ============================================================================
//  Module   : copy_len
//  Purpose  : Descriptor-controlled beat mover. Copies beats from a
//             fall-through source FIFO to a destination FIFO, or writes a
//             constant fill pattern without touching the source. Stops on
//             the programmed beat count, on the source's last beat, or on
//             enable falling.
//  Ports    : wb_clk_i / wb_rstn_i      clock, synchronous active-low reset
//             m_enable, dc              engine enable, descriptor control
//             m_len, m_fill             beat count / fill pattern (on start)
//             m_src_getn, m_src,        source pop (low), data, last flag,
//             m_src_last, m_src_empty   empty flag
//             m_dst_putn, m_dst,        destination push (low), data, last
//             m_dst_last, m_dst_full    flag, full flag
//             m_endn                    job complete (low)
//             m_count, m_short, m_abort beat count and termination flags
//  Revision : 1.0  initial release
// ============================================================================
module copy_len #(
  parameter int DW       = 64,
  parameter int LEN_W    = 16,
  parameter int SEL_BIT  = 4,
  parameter int MODE_BIT = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             m_enable,
  input  logic [23:0]      dc,
  input  logic [LEN_W-1:0] m_len,
  input  logic [DW-1:0]    m_fill,
  output logic             m_src_getn,
  input  logic [DW-1:0]    m_src,
  input  logic             m_src_last,
  input  logic             m_src_empty,
  output logic             m_dst_putn,
  output logic [DW-1:0]    m_dst,
  output logic             m_dst_last,
  input  logic             m_dst_full,
  output logic             m_endn,
  output logic [LEN_W-1:0] m_count,
  output logic             m_short,
  output logic             m_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_END  = 2'b11
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic [DW-1:0]    r_fill_pat;
  logic [LEN_W-1:0] r_count;
  logic             r_short;
  logic             r_abort;

  logic w_sel;
  logic w_fill;
  logic w_xfer;
  logic w_last;
  logic w_unused_dc;

  assign w_sel  = dc[SEL_BIT];
  assign w_fill = dc[MODE_BIT];
  // Remaining descriptor bits belong to the other engines on the bus.
  assign w_unused_dc = ^dc;

  // Beat moves in the same cycle the FIFOs show it (fall-through FIFOs).
  // Fill mode never depends on the source being non-empty.
  assign w_xfer = (r_state == S_RUN) && m_enable && !m_dst_full &&
                  (w_fill || !m_src_empty);

  // Last beat: count exhausted, or (copy only) the source marks its end.
  assign w_last = w_xfer && ((r_rem == LEN_W'(1)) || (!w_fill && m_src_last));

  // Shared bus lines are released whenever this engine is not selected.
  assign m_src_getn = w_sel ? !(w_xfer && !w_fill)             : 1'bz;
  assign m_dst_putn = w_sel ? !w_xfer                          : 1'bz;
  assign m_dst      = w_sel ? (w_fill ? r_fill_pat : m_src)    : {DW{1'bz}};
  assign m_dst_last = w_sel ? w_last                           : 1'bz;
  assign m_endn     = w_sel ? (r_state != S_END)               : 1'bz;

  assign m_count = r_count;
  assign m_short = r_short;
  assign m_abort = r_abort;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_fill_pat <= '0;
      r_count    <= '0;
      r_short    <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m_enable && w_sel) begin
            r_rem      <= m_len;
            r_fill_pat <= m_fill;
            r_count    <= '0;
            r_short    <= 1'b0;
            r_abort    <= 1'b0;
            r_state    <= (m_len == '0) ? S_END : S_RUN;
          end
        end
        S_RUN: begin
          // w_xfer already requires m_enable, so an abort cycle moves no beat.
          if (!m_enable) begin
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_xfer) begin
            // rem never underflows: the rem==1 beat always exits to END.
            r_rem <= r_rem - LEN_W'(1);
            if (r_count != '1) begin
              r_count <= r_count + LEN_W'(1);
            end
            if (w_last) begin
              r_state <= S_END;
              if (!w_fill && m_src_last && (r_rem > LEN_W'(1))) begin
                r_short <= 1'b1;
              end
            end
          end
        end
        S_END: begin
          if (!m_enable) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
